// File: rtl/regfile_pkg.sv
// regfile_pkg: register numbers, default ABI init values and clear-FSM state
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;
    localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read and bulk-clear signals between control logic and the register file
interface regfile_mp_if #(
    parameter int N        = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);

    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [N-1:0]               wdata;
    logic                       wr_ready;
    logic [NUM_READ*ADDR_W-1:0] raddr;
    logic [NUM_READ*N-1:0]      rdata;
    logic                       clr_req;
    logic                       clr_busy;

    modport master (
        output we, waddr, wdata, raddr, clr_req,
        input  wr_ready, rdata, clr_busy
    );

    modport slave (
        input  we, waddr, wdata, raddr, clr_req,
        output wr_ready, rdata, clr_busy
    );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one DEPTH:1 read mux with optional same-cycle write forwarding
module regfile_read_port #(
    parameter int N      = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [(2**ADDR_W)*N-1:0] mem,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [N-1:0]             wdata,
    output logic [N-1:0]             rdata
);

    always_comb
        rdata = (BYPASS != 0 && wr_en && waddr == raddr) ? wdata : mem[raddr*N +: N];

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired zero, ABI init values and a sequenced clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          N        = 32,
    parameter int          ADDR_W   = 5,
    parameter int          NUM_READ = 2,
    parameter int          BYPASS   = 1,
    parameter logic [31:0] GP_INIT  = GP_INIT_DEF,
    parameter logic [31:0] SP_INIT  = SP_INIT_DEF
) (
    input logic          clk,
    input logic          reset,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [N-1:0] GP_V = N'(GP_INIT);
    localparam logic [N-1:0] SP_V = N'(SP_INIT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

    function automatic logic [N-1:0] init_of(input int a);
        return (DEPTH > REG_SP && a == REG_GP) ? GP_V :
               (DEPTH > REG_SP && a == REG_SP) ? SP_V : '0;
    endfunction

    // register 0 has no storage; the flattened read bus ties its slot to zero
    logic [N-1:0]         regs [1:DEPTH-1];
    logic [DEPTH*N-1:0]   mem;
    logic [NUM_READ*N-1:0] rdata_w;
    clr_state_t           state, state_nx;
    logic [ADDR_W-1:0]    cnt, cnt_nx;
    logic                 wr_en;

    assign bus.wr_ready = state == IDLE;
    assign bus.clr_busy = state == CLEAR;
    assign bus.rdata    = rdata_w;
    assign wr_en        = bus.we && state == IDLE && bus.waddr != ADDR_W'(REG_ZERO);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE && bus.clr_req) begin
            state_nx = CLEAR;
            cnt_nx   = ADDR_W'(1);
        end else if (state == CLEAR) begin
            state_nx = (cnt == LAST) ? IDLE : CLEAR;
            cnt_nx   = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= init_of(i);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            for (int i = 1; i < DEPTH; i++)
                if (wr_en && bus.waddr == ADDR_W'(i))
                    regs[i] <= bus.wdata;
                else if (state == CLEAR && cnt == ADDR_W'(i))
                    regs[i] <= init_of(i);
        end
    end

    always_comb begin
        mem = '0;
        for (int i = 1; i < DEPTH; i++)
            mem[i*N +: N] = regs[i];
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_read_port #(
            .N      (N),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rp (
            .mem   (mem),
            .raddr (bus.raddr[k*ADDR_W +: ADDR_W]),
            .wr_en (wr_en),
            .waddr (bus.waddr),
            .wdata (bus.wdata),
            .rdata (rdata_w[k*N +: N])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for default, no-bypass and 16-bit/3-port/16-deep register files
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.N(32), .ADDR_W(5), .NUM_READ(2)) b0 ();
    regfile_mp_if #(.N(32), .ADDR_W(5), .NUM_READ(2)) b1 ();
    regfile_mp_if #(.N(16), .ADDR_W(4), .NUM_READ(3)) b2 ();

    regfile_mp #(.BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    regfile_mp #(.BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    regfile_mp #(.N(16), .ADDR_W(4), .NUM_READ(3)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    string       nm_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string nm, input logic [31:0] e, input logic [31:0] o);
        nm_q.push_back(nm);
        exp_q.push_back(e);
        obs_q.push_back(o);
    endtask

    function automatic logic [15:0] sval(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    task automatic test_reset();
        string nm;
        logic [31:0] e, o;
        reset = 1'b0;
        b0.raddr = {5'd28, 5'd29};
        b2.raddr = {4'd15, 4'd13, 4'd1};
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        sb_push("rst_sp", SP_INIT_DEF, b0.rdata[31:0]);
        sb_push("rst_gp", GP_INIT_DEF, b0.rdata[63:32]);
        sb_push("rst_busy", 32'd0, 32'(b0.clr_busy));
        sb_push("rst_ready", 32'd1, 32'(b0.wr_ready));
        sb_push("rst_s_busy", 32'd0, 32'(b2.clr_busy));
        sb_push("rst_s_r13", 32'd0, 32'(b2.rdata[31:16]));
        b0.raddr[4:0] = 5'd5;
        #1;
        sb_push("rst_r5", 32'd0, b0.rdata[31:0]);
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    task automatic test_write_read();
        string nm;
        logic [31:0] e, o;
        b0.we = 1'b1; b0.waddr = 5'd8; b0.wdata = 32'hDEAD_BEEF;
        cyc();
        b0.waddr = 5'd0; b0.wdata = 32'hCAFE_F00D;
        cyc();
        b0.waddr = 5'd31; b0.wdata = 32'h0000_0031;
        cyc();
        b0.we = 1'b0;
        b0.raddr = {5'd0, 5'd8};
        #1;
        sb_push("wr_r8", 32'hDEAD_BEEF, b0.rdata[31:0]);
        sb_push("wr_r0", 32'd0, b0.rdata[63:32]);
        b0.raddr = {5'd31, 5'd7};
        #1;
        sb_push("wr_r7", 32'd0, b0.rdata[31:0]);
        sb_push("wr_r31", 32'h0000_0031, b0.rdata[63:32]);
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    task automatic test_bypass();
        string nm;
        logic [31:0] e, o;
        b0.raddr = {5'd0, 5'd9};
        b1.raddr = {5'd0, 5'd9};
        b0.we = 1'b1; b0.waddr = 5'd9; b0.wdata = 32'h1234_5678;
        b1.we = 1'b1; b1.waddr = 5'd9; b1.wdata = 32'h1234_5678;
        #1;
        sb_push("byp_on", 32'h1234_5678, b0.rdata[31:0]);
        sb_push("byp_off_old", 32'd0, b1.rdata[31:0]);
        cyc();
        b0.waddr = 5'd0; b0.wdata = 32'hFFFF_FFFF;
        b1.we = 1'b0;
        #1;
        sb_push("byp_off_new", 32'h1234_5678, b1.rdata[31:0]);
        sb_push("byp_r0_none", 32'd0, b0.rdata[63:32]);
        sb_push("byp_r9_kept", 32'h1234_5678, b0.rdata[31:0]);
        cyc();
        b0.we = 1'b0;
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    task automatic test_clear();
        string nm;
        logic [31:0] e, o;
        int k;
        for (int i = 1; i < 32; i++) begin
            b0.we = 1'b1; b0.waddr = 5'(i); b0.wdata = 32'hFFFF_FFFF;
            cyc();
        end
        b0.we = 1'b0;
        b0.clr_req = 1'b1;
        cyc();
        b0.clr_req = 1'b0;
        k = 0;
        while (b0.clr_busy && k < 40) begin
            k++;
            if (k == 5) begin
                b0.we = 1'b1; b0.waddr = 5'd3; b0.wdata = 32'hAAAA_5555;
                b0.raddr = {5'd20, 5'd3};
                #1;
                sb_push("clr_mid_ready", 32'd0, 32'(b0.wr_ready));
                sb_push("clr_mid_r3", 32'd0, b0.rdata[31:0]);
                sb_push("clr_mid_r20", 32'hFFFF_FFFF, b0.rdata[63:32]);
            end
            if (k == 6) b0.we = 1'b0;
            if (k == 10) b0.clr_req = 1'b1;
            if (k == 11) b0.clr_req = 1'b0;
            cyc();
        end
        sb_push("clr_cycles", 32'd31, 32'(k));
        sb_push("clr_ready", 32'd1, 32'(b0.wr_ready));
        b0.raddr = {5'd29, 5'd3};
        #1;
        sb_push("clr_r3", 32'd0, b0.rdata[31:0]);
        sb_push("clr_r29", SP_INIT_DEF, b0.rdata[63:32]);
        b0.raddr = {5'd28, 5'd31};
        #1;
        sb_push("clr_r31", 32'd0, b0.rdata[31:0]);
        sb_push("clr_r28", GP_INIT_DEF, b0.rdata[63:32]);
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        string nm;
        logic [31:0] e, o;
        b0.we = 1'b1; b0.waddr = 5'd20; b0.wdata = 32'h0000_0020;
        cyc();
        b0.waddr = 5'd28; b0.wdata = 32'h0000_0001;
        cyc();
        b0.we = 1'b0;
        b0.clr_req = 1'b1;
        cyc();
        b0.clr_req = 1'b0;
        repeat (9) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        sb_push("mrst_busy", 32'd0, 32'(b0.clr_busy));
        sb_push("mrst_ready", 32'd1, 32'(b0.wr_ready));
        for (int i = 0; i < 32; i++) begin
            b0.raddr[4:0] = 5'(i);
            #1;
            sb_push($sformatf("mrst_r%0d", i),
                    (i == 28) ? GP_INIT_DEF : (i == 29) ? SP_INIT_DEF : 32'd0,
                    b0.rdata[31:0]);
        end
        cyc();
        sb_push("mrst_busy_after", 32'd0, 32'(b0.clr_busy));
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    task automatic test_scaling();
        string nm;
        logic [31:0] e, o;
        logic [3:0] pa [3][3];
        int k;
        pa[0] = '{4'd3, 4'd7, 4'd15};
        pa[1] = '{4'd0, 4'd14, 4'd1};
        pa[2] = '{4'd12, 4'd8, 4'd8};
        for (int i = 1; i < 16; i++) begin
            b2.we = 1'b1; b2.waddr = 4'(i); b2.wdata = sval(i);
            cyc();
        end
        b2.we = 1'b0;
        for (int p = 0; p < 3; p++) begin
            b2.raddr = {pa[p][2], pa[p][1], pa[p][0]};
            #1;
            for (int j = 0; j < 3; j++)
                sb_push($sformatf("s_pat%0d_port%0d", p, j),
                        (pa[p][j] == 4'd0) ? 32'd0 : 32'(sval(int'(pa[p][j]))),
                        32'(b2.rdata[j*16 +: 16]));
        end
        b2.clr_req = 1'b1;
        cyc();
        b2.clr_req = 1'b0;
        k = 0;
        while (b2.clr_busy && k < 30) begin
            k++;
            cyc();
        end
        sb_push("s_clr_cycles", 32'd15, 32'(k));
        for (int i = 0; i < 16; i++) begin
            b2.raddr[3:0] = 4'(i);
            #1;
            sb_push($sformatf("s_clr_r%0d", i), 32'd0, 32'(b2.rdata[15:0]));
        end
        while (exp_q.size() != 0) begin
            nm = nm_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    endtask

    initial begin
        b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.raddr = '0; b0.clr_req = 1'b0;
        b1.we = 1'b0; b1.waddr = '0; b1.wdata = '0; b1.raddr = '0; b1.clr_req = 1'b0;
        b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.raddr = '0; b2.clr_req = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_scaling();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS multicycle datapath, the successor to the fixed 32×32, two-read-port file. It adds a configurable read-port count, optional write-to-read bypass, a hardwired zero register, MIPS ABI reset values for $gp/$sp, and a sequenced bulk-clear engine. It sits between the control FSM (write enable/address) and the A/B operand latches.

## Interface
Parameters:
- N, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_READ, 2, number of read ports (≥1)
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to rdata
- GP_INIT, 32'h1000_8000, reset/clear value of register 28, truncated to N
- SP_INIT, 32'h7FFF_EFFC, reset/clear value of register 29, truncated to N

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge)
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  N  write data
- wr_ready  out  1  high when writes are accepted (low while clearing)
- raddr  in  NUM_READ*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_READ*N  read data; port k at [k*N +: N]
- clr_req  in  1  single-cycle request to restore all registers to init values
- clr_busy  out  1  high while the clear sequence runs

## Operation
- Init value: reg 28 = GP_INIT and reg 29 = SP_INIT when DEPTH > 29; every other register = 0.
- Register 0 always reads 0; writes to address 0 are discarded; no storage needed.
- Write: we=1, wr_ready=1, waddr≠0 → reg[waddr] ← wdata at the clock edge.
- Read: combinational, per port independent; rdata_k = reg[raddr_k].
- Bypass (BYPASS=1): when we & wr_ready & waddr≠0 & waddr==raddr_k, rdata_k = wdata. BYPASS=0 → old value until the edge.
- Clear FSM states: IDLE, CLEAR.
  - IDLE: clr_req=1 → CLEAR, cnt ← 1.
  - CLEAR: each cycle reg[cnt] ← init value; cnt ← cnt+1; at cnt == DEPTH-1, write the last register and → IDLE.
  - clr_req in CLEAR is ignored; no queueing.
- During CLEAR: wr_ready=0, we ignored (no write, no bypass). Reads return current contents, partially cleared.
- clr_req and we in the same IDLE cycle: the write completes at that edge, then the clear starts and overwrites it.

## Timing
- Reset (reset=0 at an edge): all registers ← init, state ← IDLE, cnt ← 0. Outputs next cycle: clr_busy=0, wr_ready=1, rdata = init values of the addressed registers.
- Reset has priority over writes and clears. Reset mid-clear aborts the clear and ends in the full init state.
- Write latency: 1 edge. Without bypass, new data is visible on rdata the cycle after the write.
- Clear latency: clr_req sampled at edge T → clr_busy=1 from T to T+DEPTH-1 (DEPTH-1 cycles). wr_ready=1 again after edge T+DEPTH-1.
- clr_busy and wr_ready are registered, derived from the state, and always complementary.
- cnt is ADDR_W bits wide and never wraps past DEPTH-1.

## Structure
- Package regfile_pkg holds:
  - constants REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31
  - the default GP_INIT/SP_INIT values
  - the clear-FSM state enum (IDLE, CLEAR)
- Sub-module regfile_read_port: one DEPTH:1 mux plus the bypass compare. Instantiated NUM_READ times via generate, parameterised by N, ADDR_W, BYPASS.
- Top-level regfile_mp holds the storage array, write decode, clear FSM and counter.

## Test plan
- Reset check: hold reset=0 for 2 cycles, release → raddr0=29 reads 32'h7FFF_EFFC, raddr1=28 reads 32'h1000_8000, raddr=5 reads 0; clr_busy=0, wr_ready=1.
- Basic write/read: write 32'hDEAD_BEEF to reg 8, then reg 0 → next cycle port0 (addr 8) = 32'hDEAD_BEEF, port1 (addr 0) = 0.
- Bypass: BYPASS=1, write 32'h1234_5678 to reg 9 with raddr0=9 → rdata0 = 32'h1234_5678 in the same cycle. With BYPASS=0, rdata0 holds the old value until after the edge.
- Clear: fill regs 1..31 with 32'hFFFF_FFFF, pulse clr_req → clr_busy high exactly 31 cycles. A we to reg 3 issued mid-clear is dropped. Afterwards reg 3 = 0, reg 29 = SP_INIT.
- Reset mid-clear: assert reset=0 at cycle 10 of the clear → next cycle clr_busy=0 and all registers hold init values.
- Scaling: NUM_READ=3, N=16, ADDR_W=4 → three independent ports read distinct registers correctly. The clear lasts 15 cycles and GP/SP stay 0, since DEPTH ≤ 29.
